// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: instruction geometry, the canonical NOP
// and the {pc, instr} packet handed to decode.
package fetch_pkg;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counter pair: instructions delivered and decode stall cycles.
// Built only when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        xfer,
  input  logic        stall,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q,   stall_d;

  always_comb begin
    fetched_d = fetched_q;
    stall_d   = stall_q;
    if (xfer)  fetched_d = fetched_q + 32'd1;
    if (stall) stall_d   = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;

endmodule

// File: rtl/fetch_stage.sv
// PC / fetch stage driving a 1-cycle synchronous-read instruction memory.
// Optional perf counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall
`endif
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INSTR_BYTES);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  resp_valid_q, resp_valid_d;

  // Memory address selection doubles as the next PC: whatever we ask the
  // memory for now is what pc_q must describe when the word comes back.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    imem_addr    = pc_q;
    resp_valid_d = 1'b1;
    if (rst) begin
      imem_addr = RESET_PC;
    end else if (redirect_valid) begin
      imem_addr = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    end else if (!resp_valid_q) begin
      imem_addr = pc_q;
    end else if (out_ready) begin
      imem_addr = pc_q + PC_STEP;
    end
    pc_d = imem_addr;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      pc_q         <= RESET_PC;
      resp_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // A redirect squashes the word currently on the memory bus.
  assign out_valid = resp_valid_q & ~redirect_valid & ~rst;
  assign out_pc    = pc_q;
  assign out_instr = imem_data;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf_cnt (
    .clk          (clk),
    .rst          (rst),
    .xfer         (out_valid & out_ready),
    .stall        (out_valid & ~out_ready),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stimulus, all compared against a transaction-level model of the fetch stream.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_stage #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: three fixed words, everything else a pattern of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0060_0113;
      32'h0000_0008: return 32'h0020_81b3;
      default:       return {a[31:2], 2'b11} ^ 32'h1357_9bdf;
    endcase
  endfunction

  always @(posedge clk) imem_data <= mem_word(imem_addr);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Stream model: the instruction decode is owed next and whether it is ready.
  logic [31:0] m_pc    = RESET_PC;
  logic        m_valid = 1'b0;
  int unsigned m_fetched = 0;
  int unsigned m_stalls  = 0;

  logic        o_valid;
  logic [31:0] o_pc, o_instr, o_addr;

  task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic        exp_valid, xfer;
    logic [31:0] exp_addr;
    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    exp_valid = m_valid && !rv && !r;
    xfer      = exp_valid && rdy;
    // The memory must be asked for the instruction owed in the next cycle.
    if (r)         exp_addr = RESET_PC;
    else if (rv)   exp_addr = {rpc[31:2], 2'b00};
    else if (xfer) exp_addr = m_pc + 32'd4;
    else           exp_addr = m_pc;
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    check("imem_addr", imem_addr, exp_addr);
    if (exp_valid) begin
      check("out_pc", out_pc, m_pc);
      check("out_instr", out_instr, mem_word(m_pc));
    end
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_stall", perf_stall, m_stalls);
`endif
    o_valid = out_valid;
    o_pc    = out_pc;
    o_instr = out_instr;
    o_addr  = imem_addr;
    if (xfer)                m_fetched++;
    if (exp_valid && !rdy)   m_stalls++;
    if (r) begin
      m_fetched = 0;
      m_stalls  = 0;
    end
    m_pc    = exp_addr;
    m_valid = !r;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;

    // Reset and first instructions
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_addr", o_addr, RESET_PC);
    check("rst_pc", o_pc, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 32'd0);
    check("rst_perf_stall", perf_stall, 32'd0);
`endif
    step(0, 0, 0, 1);
    check("first_bubble", {31'd0, o_valid}, 32'd0);
    step(0, 0, 0, 1);
    check("w0_valid", {31'd0, o_valid}, 32'd1);
    check("w0_pc", o_pc, 32'h0);
    check("w0_instr", o_instr, 32'h0050_0093);

    // Three stall cycles holding pc 4
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      check("stall_addr", o_addr, 32'h4);
      check("stall_pc", o_pc, 32'h4);
      check("stall_instr", o_instr, 32'h0060_0113);
    end
    step(0, 0, 0, 1);
    check("resume_pc", o_pc, 32'h4);

    // Redirect (misaligned target) while pc 8 is presented
    step(0, 1, 32'h0000_0001, 1);
    check("redir_squash", {31'd0, o_valid}, 32'd0);
    check("redir_addr", o_addr, 32'h0);
    step(0, 0, 0, 1);
    check("redir_pc", o_pc, 32'h0);
    check("redir_instr", o_instr, 32'h0050_0093);
    step(0, 0, 0, 1);
    check("redir_next_pc", o_pc, 32'h4);

    // Reset pulse mid-stream at pc 8
    step(0, 0, 0, 1);
    check("pre_rst_pc", o_pc, 32'h8);
    step(1, 0, 0, 1);
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("postrst_pc", o_pc, RESET_PC);
    check("postrst_valid", {31'd0, o_valid}, 32'd1);

    // Address wrap
    step(0, 1, 32'hffff_fffc, 1);
    step(0, 0, 0, 1);
    check("wrap_pc_hi", o_pc, 32'hffff_fffc);
    step(0, 0, 0, 1);
    check("wrap_pc_lo", o_pc, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic        r, rv, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 39) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 2))
        0:       rpc = 32'hffff_fff0 | ($urandom & 32'hf);
        1:       rpc = $urandom & 32'h0000_003f;
        default: rpc = $urandom;
      endcase
      step(r, rv, rpc, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Program-counter and fetch stage that drives the address of the synchronous-read instruction memory (1-cycle read latency) and consumes its data word.
- Presents a valid/ready stream of {pc, instr} to the decode stage.
- Handles decode back-pressure by re-issuing the held address, so memory output stays stable while stalled.
- Accepts single-cycle redirects (branch/jump) that flush the in-flight fetch.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  ADDR_WIDTH  byte address to instruction memory, combinational; sampled by memory at the next posedge.
- imem_data  input  DATA_WIDTH  memory word for the address presented in the previous cycle.
- redirect_valid  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  ADDR_WIDTH  new fetch address; bits [1:0] ignored (forced 0).
- out_valid  output  1  out_pc/out_instr hold a valid instruction.
- out_ready  input  1  decode accepts this cycle.
- out_pc  output  ADDR_WIDTH  address of out_instr.
- out_instr  output  DATA_WIDTH  instruction word (= imem_data).

Behaviour:
- State:
  - pc_q: address presented to memory in the previous cycle.
  - resp_valid: imem_data currently corresponds to pc_q and is not flushed.
- Reset (rst=1 at posedge): pc_q <= RESET_PC; resp_valid <= 0.
  - While rst is high, imem_addr = RESET_PC and out_valid = 0.
  - Reset asserted mid-stream discards any pending instruction.
- imem_addr priority (combinational):
  1. rst -> RESET_PC.
  2. redirect_valid -> {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  3. !resp_valid -> pc_q.
  4. out_ready -> pc_q + 4.
  5. Otherwise (stall) -> pc_q.
- Each non-reset posedge: pc_q <= imem_addr; resp_valid <= 1.
- Outputs:
  - out_valid = resp_valid & !redirect_valid & !rst.
  - out_pc = pc_q; out_instr = imem_data.
- Transfer occurs when out_valid & out_ready.
- Latency: first out_valid is 1 cycle after rst deasserts (PC = RESET_PC). Steady state is 1 instruction per cycle with out_ready held high.
- Stall: while out_valid & !out_ready, the same address is re-issued, so out_pc/out_instr are stable across the stall.
- Redirect: in the redirect cycle the current response is squashed (out_valid=0, no transfer even if out_ready=1). The next cycle presents the instruction at redirect_pc (1-cycle bubble).
- Redirect during stall: the redirect wins and the stalled instruction is dropped.
- PC arithmetic: unsigned, modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC + 4 wraps to 0.
- Reset values: imem_addr = RESET_PC, out_valid = 0, out_pc = RESET_PC. out_instr follows memory and is don't-care while out_valid = 0.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched (32) and perf_stall (32), both cleared by rst.
  - perf_fetched increments on each transfer.
  - perf_stall increments each cycle with out_valid & !out_ready.
  - Both counters wrap at 2^32.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - INSTR_BYTES = 4.
  - NOP = 32'h0000_0013.
  - typedef fetch_pkt_t {pc, instr}, for decode-side reuse.
- Sub-module fetch_perf_cnt (counter pair), instantiated only under FETCH_PERF_CNT_EN.
- The core PC logic stays in fetch_stage.

Test Plan:
- Setup: bench memory model with 1-cycle synchronous read; word0 = 32'h00500093, word1 = 32'h00600113, word2 = 32'h002081b3.
- Reset release, out_ready=1 -> out_valid rises 1 cycle after rst falls. Outputs are (pc 0, 00500093), (4, 00600113), (8, 002081b3) on consecutive cycles.
- out_ready=0 for 3 cycles while presenting pc 4 -> imem_addr = 4 throughout; out_pc/out_instr stable at 4/00600113. Resumes with pc 8 the cycle after out_ready=1.
- redirect_valid with redirect_pc=0x0000_0001 while presenting pc 8 -> out_valid=0 that cycle. Next cycle shows pc 0, instr 00500093, then pc 4.
- rst pulsed for 1 cycle mid-stream at pc 8 -> out_valid=0 during reset; the next valid output is pc 0.
- Wrap-around: redirect to 32'hFFFF_FFFC, out_ready=1 -> out_pc sequence FFFF_FFFC, 0000_0000.
- With FETCH_PERF_CNT_EN defined: 5 transfers and 3 stall cycles -> perf_fetched=5, perf_stall=3. Both read 0 after rst.
